// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional statistics counters are built only when BRANCH_PREDICTOR_STATS_EN is defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [`ADDR_WIDTH-1:0] pc,
    output logic                   take_branch,
    output logic [`ADDR_WIDTH-1:0] branch_predict,
    input  logic                   update_valid,
    input  logic [`ADDR_WIDTH-1:0] update_pc,
    input  logic                   update_taken,
    input  logic [`ADDR_WIDTH-1:0] update_target,
    input  logic                   update_mispredict,
    input  logic                   clear,
    output logic [15:0]            stat_updates,
    output logic [15:0]            stat_mispredicts
);
    localparam int AW   = `ADDR_WIDTH;
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = AW - IDX - 1;

    logic [ENTRIES-1:0] valid;
    logic [TAGW-1:0]    tag_mem [ENTRIES];
    logic [AW-1:0]      target_mem [ENTRIES];
    logic [1:0]         ctr_mem [ENTRIES];

    logic [IDX-1:0]  look_idx;
    logic [TAGW-1:0] look_tag;
    logic            look_hit;
    logic [IDX-1:0]  upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;

    // Bit 0 of an address never selects an entry: instructions are 2-byte aligned.
    assign look_idx = pc[IDX:1];
    assign look_tag = pc[AW-1:IDX+1];
    assign upd_idx  = update_pc[IDX:1];
    assign upd_tag  = update_pc[AW-1:IDX+1];

    assign look_hit       = valid[look_idx] && (tag_mem[look_idx] == look_tag);
    assign take_branch    = look_hit && ctr_mem[look_idx][1];
    assign branch_predict = take_branch ? target_mem[look_idx] : pc + AW'(2);

    assign upd_hit = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);

    // update_valid is a single-cycle pulse per resolved branch; there is no back-pressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
                ctr_mem[i]    <= 2'b01;
            end
        end else if (clear) begin
            valid <= '0;
        end else if (update_valid) begin
            if (upd_hit) begin
                if (update_taken) begin
                    if (ctr_mem[upd_idx] != 2'b11) ctr_mem[upd_idx] <= ctr_mem[upd_idx] + 2'd1;
                    target_mem[upd_idx] <= update_target;
                end else if (ctr_mem[upd_idx] != 2'b00) begin
                    ctr_mem[upd_idx] <= ctr_mem[upd_idx] - 2'd1;
                end
            end else if (update_taken) begin
                valid[upd_idx]      <= 1'b1;
                tag_mem[upd_idx]    <= upd_tag;
                target_mem[upd_idx] <= update_target;
                ctr_mem[upd_idx]    <= 2'b10;
            end
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [15:0] upd_cnt;
    logic [15:0] mis_cnt;
    logic        unused_bits;

    assign unused_bits = update_pc[0];

    // A mispredict is counted on its own flag, even in a cycle where clear drops the update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_cnt <= '0;
            mis_cnt <= '0;
        end else begin
            if (update_valid && !clear && upd_cnt != 16'hFFFF) upd_cnt <= upd_cnt + 16'd1;
            if (update_valid && update_mispredict && mis_cnt != 16'hFFFF) mis_cnt <= mis_cnt + 16'd1;
        end
    end

    assign stat_updates     = upd_cnt;
    assign stat_mispredicts = mis_cnt;
`else
    logic [1:0] unused_bits;

    assign unused_bits      = {update_pc[0], update_mispredict};
    assign stat_updates     = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, 16-bit addresses).
// Stat expectations follow BRANCH_PREDICTOR_STATS_EN when it is defined.
`timescale 1ns/1ps

module tb_branch_predictor;
    logic        clk;
    logic        reset;
    logic [15:0] pc;
    logic        take_branch;
    logic [15:0] branch_predict;
    logic        update_valid;
    logic [15:0] update_pc;
    logic        update_taken;
    logic [15:0] update_target;
    logic        update_mispredict;
    logic        clear;
    logic [15:0] stat_updates;
    logic [15:0] stat_mispredicts;

    int n_checks = 0;
    int n_errors = 0;
    logic [16:0] exp_q[$];
    logic [15:0] exp_upd = 16'd0;
    logic [15:0] exp_mis = 16'd0;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .pc                (pc),
        .take_branch       (take_branch),
        .branch_predict    (branch_predict),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .clear             (clear),
        .stat_updates      (stat_updates),
        .stat_mispredicts  (stat_mispredicts)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the rising edge after that commits any update.
    task automatic drive(input logic [15:0] p, input logic uv, input logic [15:0] upc,
                         input logic ut, input logic [15:0] utg, input logic umis,
                         input logic clr);
        @(negedge clk);
        pc = p; update_valid = uv; update_pc = upc; update_taken = ut;
        update_target = utg; update_mispredict = umis; clear = clr;
`ifdef BRANCH_PREDICTOR_STATS_EN
        if (uv && !clr && exp_upd != 16'hFFFF) exp_upd++;
        if (uv && umis && exp_mis != 16'hFFFF) exp_mis++;
`endif
        #1;
    endtask

    task automatic idle(input logic [15:0] p);
        drive(p, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    // scoreboard: expected {take_branch, branch_predict} for the current pc
    task automatic expect_lookup(input string tag, input logic exp_take, input logic [15:0] exp_bp);
        logic [16:0] e;
        exp_q.push_back({exp_take, exp_bp});
        e = exp_q.pop_front();
        check({tag, ".take"}, {31'd0, take_branch}, {31'd0, e[16]});
        check({tag, ".predict"}, {16'd0, branch_predict}, {16'd0, e[15:0]});
    endtask

    task automatic expect_stats(input string tag);
        check({tag, ".updates"}, {16'd0, stat_updates}, {16'd0, exp_upd});
        check({tag, ".mispredicts"}, {16'd0, stat_mispredicts}, {16'd0, exp_mis});
    endtask

    initial begin
        reset = 1'b0; pc = 16'h0010; update_valid = 1'b0; update_pc = 16'h0;
        update_taken = 1'b0; update_target = 16'h0; update_mispredict = 1'b0; clear = 1'b0;
        #12;
        expect_lookup("in_reset", 1'b0, 16'h0012);
        expect_stats("in_reset");
        @(negedge clk);
        reset = 1'b1;

        idle(16'h0010);
        expect_lookup("after_reset", 1'b0, 16'h0012);

        // allocate 0x0010 while looking it up in the same cycle
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b0);
        expect_lookup("same_cycle", 1'b0, 16'h0012);
        idle(16'h0010);
        expect_lookup("alloc_hit", 1'b1, 16'h0040);
        idle(16'h0030);
        expect_lookup("alias_tag", 1'b0, 16'h0032);
        idle(16'h0011);
        expect_lookup("odd_addr", 1'b1, 16'h0040);

        // counter walk from 10
        drive(16'h0010, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 1'b0);
        idle(16'h0010);
        expect_lookup("walk_nt_01", 1'b0, 16'h0012);
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1, 1'b0);
        idle(16'h0010);
        expect_lookup("walk_t_10", 1'b1, 16'h0040);
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b0);
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b0);
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0050, 1'b0, 1'b0);
        idle(16'h0010);
        expect_lookup("walk_sat_11", 1'b1, 16'h0050);
        drive(16'h0010, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);
        idle(16'h0010);
        expect_lookup("walk_nt_10", 1'b1, 16'h0050);
        drive(16'h0010, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);
        idle(16'h0010);
        expect_lookup("walk_nt_01b", 1'b0, 16'h0012);
        expect_stats("walk");

        // not-taken miss leaves the table alone
        drive(16'h0030, 1'b1, 16'h0030, 1'b0, 16'h0099, 1'b0, 1'b0);
        idle(16'h0030);
        expect_lookup("nt_miss", 1'b0, 16'h0032);

        // retrain 0x0010, then clear with a simultaneous allocate of 0x0020
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0060, 1'b0, 1'b0);
        idle(16'h0010);
        expect_lookup("retrain", 1'b1, 16'h0060);
        expect_stats("pre_clear");
        drive(16'h0010, 1'b1, 16'h0020, 1'b1, 16'h0070, 1'b0, 1'b1);
        idle(16'h0010);
        expect_lookup("clear_0010", 1'b0, 16'h0012);
        idle(16'h0020);
        expect_lookup("clear_0020", 1'b0, 16'h0022);
        expect_stats("post_clear");

        idle(16'hFFFE);
        expect_lookup("wrap", 1'b0, 16'h0000);

        // asynchronous reset mid-run
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0080, 1'b1, 1'b0);
        idle(16'h0010);
        expect_lookup("pre_async", 1'b1, 16'h0080);
        #2;
        reset = 1'b0;
        exp_upd = 16'd0;
        exp_mis = 16'd0;
        #1;
        expect_lookup("async_reset", 1'b0, 16'h0012);
        expect_stats("async_reset");
        @(negedge clk);
        reset = 1'b1;

`ifdef BRANCH_PREDICTOR_STATS_EN
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b0);
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1, 1'b0);
        drive(16'h0010, 1'b1, 16'h0030, 1'b0, 16'h0040, 1'b0, 1'b0);
        idle(16'h0010);
        check("stats3.updates", {16'd0, stat_updates}, 32'd3);
        check("stats3.mispredicts", {16'd0, stat_mispredicts}, 32'd1);
        for (int i = 0; i < 65535; i++)
            drive(16'h0010, 1'b1, 16'h0030, 1'b0, 16'h0000, 1'b1, 1'b0);
        idle(16'h0010);
        check("sat.updates", {16'd0, stat_updates}, 32'hFFFF);
        check("sat.mispredicts", {16'd0, stat_mispredicts}, 32'hFFFF);
`else
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1, 1'b0);
        idle(16'h0010);
        check("off.updates", {16'd0, stat_updates}, 32'd0);
        check("off.mispredicts", {16'd0, stat_mispredicts}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of table entries; power of 2, range 2..64; IDX = log2(ENTRIES).
REQ-002 clk  input  1  single clock; all state on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 pc  input  `ADDR_WIDTH  current fetch address from the program counter.
REQ-005 take_branch  output  1  predicted-taken for pc; combinational from registered table state.
REQ-006 branch_predict  output  `ADDR_WIDTH  predicted next pc: stored target on taken-hit, else pc+2.
REQ-007 update_valid  input  1  a branch resolved this cycle in execute.
REQ-008 update_pc  input  `ADDR_WIDTH  address of the resolved branch.
REQ-009 update_taken  input  1  resolved direction.
REQ-010 update_target  input  `ADDR_WIDTH  resolved target address.
REQ-011 update_mispredict  input  1  execute flagged a misprediction; stats only.
REQ-012 clear  input  1  synchronous invalidate of the whole table.
REQ-013 stat_updates  output  16  count of accepted updates.
REQ-014 stat_mispredicts  output  16  count of mispredicts.

Function
REQ-015 Entry = valid, tag, target[`ADDR_WIDTH], ctr[2]; index = addr[IDX:1], tag = addr[`ADDR_WIDTH-1:IDX+1]; addr[0] is ignored.
REQ-016 Lookup hit = valid && stored tag == pc tag; take_branch = hit && ctr[1]; zero-cycle latency.
REQ-017 branch_predict = target when take_branch, else pc+2, modulo 2^`ADDR_WIDTH (0xFFFE wraps to 0x0000 at width 16).
REQ-018 Update hit with taken: ctr saturating increment (max 2'b11), target <= update_target.
REQ-019 Update hit with not-taken: ctr saturating decrement (min 2'b00); target unchanged; entry stays valid.
REQ-020 Update miss with taken: allocate or replace the indexed entry; valid=1, tag, target, ctr=2'b10.
REQ-021 Update miss with not-taken: table unchanged.
REQ-022 Update and lookup on the same index in one cycle: lookup returns the pre-update contents; new contents are visible from the next cycle.
REQ-023 clear=1: all valid bits go to 0 at the edge; clear takes priority over a simultaneous update, which is dropped.
REQ-024 Counters and targets of cleared entries are don't-care; a cleared entry is never a hit.
REQ-025 The block has no stall input; upstream holds pc steady and update_valid is a one-cycle pulse per branch.

Reset
REQ-026 reset=0 immediately clears all valid bits, all ctr to 2'b01, and stat_updates and stat_mispredicts to 0, independent of clk.
REQ-027 While in reset, take_branch=0 and branch_predict=pc+2.
REQ-028 After release, the first update edge is the first posedge with reset=1; an update that coincides with reset assertion is lost.

Configuration
REQ-029 Macro BRANCH_PREDICTOR_STATS_EN defined: stat_updates increments on each update_valid not dropped by clear; stat_mispredicts increments on update_valid && update_mispredict; both saturate at 0xFFFF.
REQ-030 Macro not defined: both stat ports remain present and are tied to 0; no counter logic is instantiated.

Verification
REQ-031 Reset, pc=0x0010 -> take_branch=0, branch_predict=0x0012.
REQ-032 Update pc=0x0010, taken, target=0x0040; next cycle pc=0x0010 -> take_branch=1, branch_predict=0x0040. Then pc=0x0030, which has the same index and a different tag -> take_branch=0, branch_predict=0x0032.
REQ-033 Counter walk on 0x0010, starting from ctr=2'b10:
- not-taken -> ctr=01, prediction 0;
- taken -> ctr=10, prediction 1;
- 3x taken -> saturates at 11;
- then 2x not-taken -> ctr=01, prediction 0.
REQ-034 Same-cycle lookup and allocating update on pc 0x0010 -> that cycle take_branch=0; next cycle take_branch=1.
REQ-035 clear with a simultaneous taken update on 0x0020 -> next cycle, lookups of 0x0010 and 0x0020 both give take_branch=0; stat_updates unchanged.
REQ-036 With BRANCH_PREDICTOR_STATS_EN: 3 updates, 1 with mispredict -> stat_updates=3, stat_mispredicts=1. Preload to 0xFFFF and update -> stays 0xFFFF. Without the macro both read 0.
